// File: rtl/way_victim_alloc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | way_alloc_pkg : shared constants and FSM encoding for way allocation |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package way_alloc_pkg;
    localparam int WAYS  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/way_victim_alloc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | way_victim_alloc_if : request/response bundle for the way allocator  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface way_victim_alloc_if;
    import way_alloc_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [WAYS-1:0]  valid_mask;
    logic [WAYS-1:0]  lock_mask;
    logic             resp_valid;
    logic             resp_ready;
    logic [WAYS-1:0]  resp_onehot;
    logic [IDX_W-1:0] resp_index;
    logic             resp_none;
    logic             resp_replace;

    modport master (
        output req_valid, valid_mask, lock_mask, resp_ready,
        input  req_ready, resp_valid, resp_onehot, resp_index, resp_none, resp_replace
    );

    modport slave (
        input  req_valid, valid_mask, lock_mask, resp_ready,
        output req_ready, resp_valid, resp_onehot, resp_index, resp_none, resp_replace
    );
endinterface
`default_nettype wire

// File: rtl/way_victim_alloc_idx2onehot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | idx2onehot : index to one-hot decoder with enable                    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module idx2onehot
    import way_alloc_pkg::*;
(
    input  wire logic [IDX_W-1:0] i_idx,
    input  wire logic             i_en,
    output logic      [WAYS-1:0]  o_onehot
);
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < WAYS; i++) begin
            o_onehot[i] = i_en && (i_idx == IDX_W'(i));
        end
    end
endmodule
`default_nettype wire

// File: rtl/way_victim_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | way_victim_alloc : picks lowest free way, else round-robin victim    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module way_victim_alloc
    import way_alloc_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    way_victim_alloc_if.slave  bus
);
    state_t           r_state;
    logic [WAYS-1:0]  r_valid_cap;
    logic [WAYS-1:0]  r_lock_cap;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [WAYS-1:0]  r_resp_onehot;
    logic [IDX_W-1:0] r_resp_index;
    logic             r_resp_none;
    logic             r_resp_replace;

    logic [WAYS-1:0]  w_elig;
    logic [WAYS-1:0]  w_free;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_rot;
    logic             w_found;
    logic             w_replace;
    logic [WAYS-1:0]  w_onehot;

    // Downward loops let the lowest matching position be the last write.
    always_comb begin
        w_elig    = ~r_lock_cap;
        w_free    = w_elig & ~r_valid_cap;
        w_sel_idx = '0;
        w_rot     = '0;
        w_found   = 1'b0;
        w_replace = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_sel_idx = IDX_W'(i);
                w_found   = 1'b1;
            end
        end
        if (!w_found) begin
            for (int k = WAYS - 1; k >= 0; k--) begin
                w_rot = r_rr_ptr + IDX_W'(k);
                if (w_elig[w_rot]) begin
                    w_sel_idx = w_rot;
                    w_found   = 1'b1;
                    w_replace = 1'b1;
                end
            end
        end
    end

    idx2onehot u_idx2onehot (
        .i_idx    (w_sel_idx),
        .i_en     (w_found),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_valid_cap    <= '0;
            r_lock_cap     <= '0;
            r_rr_ptr       <= '0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_onehot  <= '0;
            r_resp_index   <= '0;
            r_resp_none    <= 1'b0;
            r_resp_replace <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_valid_cap <= bus.valid_mask;
                        r_lock_cap  <= bus.lock_mask;
                        r_req_ready <= 1'b0;
                        r_state     <= CALC;
                    end
                end
                CALC: begin
                    r_resp_index   <= w_sel_idx;
                    r_resp_onehot  <= w_onehot;
                    r_resp_none    <= ~w_found;
                    r_resp_replace <= w_replace;
                    r_resp_valid   <= 1'b1;
                    r_state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        if (r_resp_replace) begin
                            r_rr_ptr <= r_resp_index + IDX_W'(1);
                        end
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_onehot  = r_resp_onehot;
    assign bus.resp_index   = r_resp_index;
    assign bus.resp_none    = r_resp_none;
    assign bus.resp_replace = r_resp_replace;
endmodule
`default_nettype wire

// File: doc/way_victim_alloc.md
Name: way_victim_alloc

Overview:
- Allocates one cache way per request in the NPC cache refill path.
- Policy: the lowest-indexed free way wins; if no way is free, a round-robin replacement pointer picks the victim.
- Returns the chosen way as both a 4-bit index and a 16-bit one-hot mask, so the refill datapath can drive way write-enables directly.
- This block produces one-hot from index; it is the counterpart of the existing one-hot-to-index encoder used on the hit path.

Parameters:
- WAYS, 16, number of ways; must be a power of two, 2..16.
- IDX_W, 4, index width; equals log2(WAYS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  allocation request.
- req_ready  out  1  block can accept a request.
- valid_mask  in  WAYS  bit i = 1 means way i holds valid data; sampled at request accept.
- lock_mask  in  WAYS  bit i = 1 means way i must not be chosen; sampled at request accept.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_onehot  out  WAYS  chosen way as one-hot; all zero when resp_none = 1.
- resp_index  out  IDX_W  chosen way index; 0 when resp_none = 1.
- resp_none  out  1  no way is eligible.
- resp_replace  out  1  chosen way held valid data (eviction required).

Behaviour:
- Reset, applied when rst_n = 0 at a clk edge, regardless of state:
  - state = IDLE, rr_ptr = 0.
  - Outputs: req_ready = 1, resp_valid = 0, resp_onehot = 0, resp_index = 0, resp_none = 0, resp_replace = 0.
  - Reset mid-transaction drops the pending response.
- States and transitions:
  - IDLE: req_ready = 1. On req_valid = 1, capture valid_mask and lock_mask, go to CALC.
  - CALC: req_ready = 0. Compute the result, register it into the resp_* outputs, go to RESP.
  - RESP: resp_valid = 1, resp_* held stable. On resp_ready = 1, go to IDLE.
- Latency and throughput:
  - Request accepted at cycle T; resp_valid first asserts at T+2.
  - resp_valid stays high until the handshake.
  - Minimum request-to-request spacing is 3 cycles.
  - req_ready = 0 in CALC and RESP; a request cannot overlap a pending response.
- Selection, with eligible = ~lock_mask:
  1. free = eligible & ~valid_mask. If free != 0, choose the lowest set bit of free. resp_replace = 0.
  2. Otherwise, if eligible != 0, choose the first set bit of eligible scanning upward from rr_ptr, wrapping WAYS-1 -> 0. resp_replace = 1.
  3. Otherwise resp_none = 1, resp_onehot = 0, resp_index = 0, resp_replace = 0.
- Pointer update:
  - rr_ptr changes only on the RESP handshake and only when resp_replace = 1.
  - New value is resp_index + 1, modulo WAYS (15 -> 0 wraps).
  - Free-way picks and none results leave rr_ptr unchanged.
- Invariants:
  - resp_onehot == (1 << resp_index) whenever resp_none = 0.
  - resp_onehot has at most one bit set.
  - Changes to the mask inputs after capture have no effect on the pending result.

Decomposition:
- Shared package way_alloc_pkg:
  - constants WAYS and IDX_W;
  - state enum {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2}.
- Sub-module idx2onehot: combinational, IDX_W-bit index in, WAYS-bit one-hot out, plus an enable input (output all zero when enable = 0).
- The lowest-set-bit search and the rotated search live in way_victim_alloc.

Test Plan:
- Post-reset request with valid_mask=16'h00FF, lock_mask=0 -> at T+2: resp_index=8, resp_onehot=16'h0100, resp_replace=0; rr_ptr stays 0.
- All valid (16'hFFFF), lock=0, four consecutive requests -> indices 0, 1, 2, 3 with resp_replace=1; rr_ptr ends at 4.
- rr_ptr=15 (after a victim at 14), all valid, lock=16'h8001 -> index 1 (wrap skips locked 15 and 0); rr_ptr becomes 2.
- lock_mask=16'hFFFF -> resp_none=1, resp_onehot=0, resp_index=0; rr_ptr unchanged.
- Hold resp_ready=0 for 5 cycles and toggle the masks meanwhile -> resp_* stable, req_ready=0 throughout; handshake on cycle 6 returns to IDLE.
- Drive rst_n=0 for one cycle while in RESP -> next cycle resp_valid=0, req_ready=1; a following all-valid request returns index 0.
